// File: rtl/dm_handshake_slave.sv
// Multi-cycle data-memory responder: valid/ready request channel, fixed-latency response pulse,
// 4 KiB little-endian byte-addressable array with byte/half/word access and sign/zero extension.
module dm_handshake_slave #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int         DEPTH    = 2 ** (ADDR_W - 2);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_next;

    logic [3:0]        count;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic [31:0] mem [DEPTH];

    logic accept;
    logic enter_resp;

    logic              op_we;
    logic [1:0]        op_size;
    logic              op_signed;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;
    logic              op_err;
    logic [1:0]        op_off;
    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       cur_word;
    logic [31:0]       shifted;
    logic [31:0]       load_val;
    logic [31:0]       store_word;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY = 1 the commit happens on the accept edge, so the live inputs are the operands.
    always_comb begin
        op_we     = lat_we;
        op_size   = lat_size;
        op_signed = lat_signed;
        op_addr   = lat_addr;
        op_wdata  = lat_wdata;
        if (state == IDLE) begin
            op_we     = req_we;
            op_size   = req_size;
            op_signed = req_signed;
            op_addr   = req_addr;
            op_wdata  = req_wdata;
        end
    end

    always_comb begin
        op_off   = op_addr[1:0];
        word_idx = op_addr[ADDR_W-1:2];
        op_err   = (op_size == 2'b11) ||
                   (op_size == 2'b01 && op_off[0]) ||
                   (op_size == 2'b10 && op_off != 2'b00);
        cur_word = mem[word_idx];
        shifted  = cur_word >> {op_off, 3'b000};
        case (op_size)
            2'b00:   load_val = {{24{op_signed & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{op_signed & shifted[15]}}, shifted[15:0]};
            default: load_val = cur_word;
        endcase
        store_word = cur_word;
        case (op_size)
            2'b00:   store_word[{op_off, 3'b000} +: 8]     = op_wdata[7:0];
            2'b01:   store_word[{op_off[1], 4'b0000} +: 16] = op_wdata[15:0];
            default: store_word = op_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            count      <= 4'd0;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= 32'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == IDLE);
            if (accept) begin
                lat_we     <= req_we;
                lat_size   <= req_size;
                lat_signed <= req_signed;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                count      <= CNT_INIT;
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end
            // Response fields are only non-zero during the single RESP cycle.
            resp_valid <= enter_resp;
            resp_err   <= enter_resp & op_err;
            resp_rdata <= (enter_resp && !op_err && !op_we) ? load_val : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (enter_resp && op_we && !op_err) begin
            mem[word_idx] <= store_word;
        end
    end

endmodule
